// File: rtl/sync_addsub_checker_if.sv
// sync_addsub_checker_if: operand stream and adder-result bundle watched by the checker
interface sync_addsub_checker_if #(parameter int N = 4);
  logic en;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic opsel;
  logic [N-1:0] dut_sum;
  logic dut_carry;
  logic dut_ovf;
  modport master(output en, a, b, opsel, dut_sum, dut_carry, dut_ovf);
  modport slave(input en, a, b, opsel, dut_sum, dut_carry, dut_ovf);
endinterface

// File: rtl/sync_addsub_checker.sv
// sync_addsub_checker: predicts add/sub results, delays them by the adder latency and scores the adder outputs
module sync_addsub_checker #(
  parameter int N = 4,
  parameter int LATENCY = 1,
  parameter int CW = 16,
  parameter int EW = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  sync_addsub_checker_if.slave  bus,
  output logic [N-1:0]          exp_sum,
  output logic                  chk_valid,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [CW-1:0]         chk_count,
  output logic [EW-1:0]         err_count,
  output logic [2*N:0]          first_err,
  output logic [1:0]            state
);
  localparam int W = 3*N+3;
  typedef enum logic [1:0] {IDLE, FILL, CHECK, FAIL} st_t;
  st_t st, st_nx;
  logic [N:0] sum;
  logic [N-1:0] bx;
  logic ovf;
  logic [W-1:0] pd [LATENCY];
  logic [LATENCY-1:0] pv;
  logic [N-1:0] p_sum;
  logic p_c, p_ovf;
  logic [2*N:0] p_tag;
  logic cmp, mis;
  always_comb begin
    bx = bus.opsel ? ~bus.b : bus.b;
    sum = {1'b0, bus.a} + {1'b0, bx} + {{N{1'b0}}, bus.opsel};
    ovf = (bus.a[N-1] == bx[N-1]) && (sum[N-1] != bus.a[N-1]);
  end
  assign {p_sum, p_c, p_ovf, p_tag} = pd[LATENCY-1];
  assign cmp = pv[LATENCY-1];
  assign mis = cmp && ({bus.dut_sum, bus.dut_carry, bus.dut_ovf} != {p_sum, p_c, p_ovf});
  assign state = st;
  // tuple payload needs no reset; only the valid bits gate comparisons
  always_ff @(posedge CLOCK_50) begin
    pd[0] <= {sum[N-1:0], sum[N], ovf, bus.opsel, bus.a, bus.b};
    for (int i = 1; i < LATENCY; i++) pd[i] <= pd[i-1];
    pv <= reset ? '0 : (pv << 1) | LATENCY'(bus.en);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st <= IDLE;
      exp_sum <= '0;
      chk_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_sticky <= 1'b0;
      chk_count <= '0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      st <= st_nx;
      chk_valid <= cmp;
      err_pulse <= mis;
      if (cmp) exp_sum <= p_sum;
      if (cmp && !(&chk_count)) chk_count <= chk_count + CW'(1);
      if (mis && !(&err_count)) err_count <= err_count + EW'(1);
      if (mis) err_sticky <= 1'b1;
      if (mis && !err_sticky) first_err <= p_tag;
    end
  end
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    st_nx = bus.en ? FILL : IDLE;
      FILL:    st_nx = !cmp ? FILL : mis ? FAIL : CHECK;
      CHECK:   st_nx = mis ? FAIL : CHECK;
      default: st_nx = FAIL;
    endcase
  end
endmodule

// File: tb/tb_sync_addsub_checker.sv
// tb_sync_addsub_checker: directed vectors plus random traffic against an arithmetic reference model
module tb_sync_addsub_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  sync_addsub_checker_if #(.N(4)) ifa();
  sync_addsub_checker_if #(.N(4)) ifb();
  logic [3:0] a_exp, b_exp;
  logic a_cv, a_ep, a_st, b_cv, b_ep, b_st;
  logic [15:0] a_cc, b_cc;
  logic [7:0] a_ec;
  logic [1:0] b_ec;
  logic [8:0] a_fe, b_fe;
  logic [1:0] a_state, b_state;
  sync_addsub_checker #(.N(4), .LATENCY(1), .CW(16), .EW(8)) dut_a (
    .CLOCK_50(clk), .reset(rst), .bus(ifa), .exp_sum(a_exp), .chk_valid(a_cv),
    .err_pulse(a_ep), .err_sticky(a_st), .chk_count(a_cc), .err_count(a_ec),
    .first_err(a_fe), .state(a_state));
  sync_addsub_checker #(.N(4), .LATENCY(3), .CW(16), .EW(2)) dut_b (
    .CLOCK_50(clk), .reset(rst), .bus(ifb), .exp_sum(b_exp), .chk_valid(b_cv),
    .err_pulse(b_ep), .err_sticky(b_st), .chk_count(b_cc), .err_count(b_ec),
    .first_err(b_fe), .state(b_state));
  typedef struct {
    logic en; logic [3:0] a; logic [3:0] b; logic op;
    logic frc; logic [3:0] fs;
    logic ev; logic [3:0] es; logic ee;
  } vec_t;
  vec_t tbl[11];
  int total = 0, bad = 0, t = 0, last_rst = -1;
  logic [9:0] hist[4096];
  int lat[2] = '{1, 3};
  int emax[2] = '{255, 3};
  logic [5:0] drv[2], fm[2];
  logic fo[2];
  logic [3:0] fv[2];
  logic m_v[2], m_e[2], m_s[2];
  logic [3:0] m_x[2];
  int m_c[2], m_k[2], m_st[2];
  logic [8:0] m_f[2];
  function automatic logic [5:0] ideal(logic [3:0] a, logic [3:0] b, logic op);
    int sa, sb, r, sr;
    logic c, o;
    r = op ? int'(a) - int'(b) : int'(a) + int'(b);
    c = op ? (a >= b) : (r > 15);
    sa = a > 7 ? int'(a) - 16 : int'(a);
    sb = b > 7 ? int'(b) - 16 : int'(b);
    sr = op ? sa - sb : sa + sb;
    o = sr > 7 || sr < -8;
    return {4'((r + 16) % 16), c, o};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask
  task automatic drive(logic e, logic [3:0] x, logic [3:0] y, logic o);
    ifa.en = e; ifa.a = x; ifa.b = y; ifa.opsel = o;
    ifb.en = e; ifb.a = x; ifb.b = y; ifb.opsel = o;
  endtask
  task automatic set_dut();
    logic [9:0] h;
    logic [5:0] d;
    for (int i = 0; i < 2; i++) begin
      h = (t - lat[i] >= 0) ? hist[t - lat[i]] : '0;
      d = ideal(h[7:4], h[3:0], h[8]) ^ fm[i];
      if (fo[i]) d[5:2] = fv[i];
      drv[i] = d;
    end
    {ifa.dut_sum, ifa.dut_carry, ifa.dut_ovf} = drv[0];
    {ifb.dut_sum, ifb.dut_carry, ifb.dut_ovf} = drv[1];
  endtask
  task automatic model(int i);
    logic v, mis;
    logic [9:0] h;
    logic [5:0] e;
    int idx;
    idx = t - lat[i];
    h = idx >= 0 ? hist[idx] : '0;
    v = idx >= 0 && h[9] && last_rst < idx;
    e = ideal(h[7:4], h[3:0], h[8]);
    mis = v && drv[i] != e;
    m_v[i] = v;
    m_e[i] = mis;
    if (v) begin
      m_x[i] = e[5:2];
      if (m_c[i] < 65535) m_c[i]++;
    end
    if (mis) begin
      if (m_k[i] < emax[i]) m_k[i]++;
      if (!m_s[i]) m_f[i] = {h[8], h[7:4], h[3:0]};
      m_s[i] = 1'b1;
    end
    case (m_st[i])
      0: if (hist[t][9]) m_st[i] = 1;
      1: if (v) m_st[i] = mis ? 3 : 2;
      2: if (mis) m_st[i] = 3;
      default: ;
    endcase
  endtask
  task automatic tick();
    set_dut();
    @(posedge clk);
    hist[t] = {ifa.en, ifa.opsel, ifa.a, ifa.b};
    if (rst) begin
      last_rst = t;
      for (int i = 0; i < 2; i++) begin
        m_v[i] = 0; m_e[i] = 0; m_s[i] = 0; m_x[i] = 0;
        m_c[i] = 0; m_k[i] = 0; m_f[i] = 0; m_st[i] = 0;
      end
    end else begin
      model(0);
      model(1);
    end
    t++;
    #1;
    chk("a_valid", a_cv, m_v[0]);
    chk("a_pulse", a_ep, m_e[0]);
    chk("a_sum", a_exp, m_x[0]);
    chk("a_sticky", a_st, m_s[0]);
    chk("a_chk_count", a_cc, m_c[0]);
    chk("a_err_count", a_ec, m_k[0]);
    chk("a_first", a_fe, m_f[0]);
    chk("a_state", a_state, m_st[0]);
    chk("b_valid", b_cv, m_v[1]);
    chk("b_pulse", b_ep, m_e[1]);
    chk("b_sum", b_exp, m_x[1]);
    chk("b_sticky", b_st, m_s[1]);
    chk("b_chk_count", b_cc, m_c[1]);
    chk("b_err_count", b_ec, m_k[1]);
    chk("b_first", b_fe, m_f[1]);
    chk("b_state", b_state, m_st[1]);
  endtask
  initial begin
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 1, 2, 0};
    tbl[2]  = '{1, 15, 13, 0, 0, 0, 1, 6, 0};
    tbl[3]  = '{1, 2, 5, 1, 0, 0, 1, 12, 0};
    tbl[4]  = '{1, 8, 1, 1, 0, 0, 1, 13, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 7, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 0, 7, 0};
    tbl[8]  = '{1, 3, 4, 0, 1, 3, 1, 2, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 7, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 7, 0};
    for (int i = 0; i < 2; i++) begin
      fm[i] = '0; fo[i] = 1'b0; fv[i] = '0;
    end
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_valid", a_cv, 0);
    chk("idle_count", a_cc, 0);
    chk("idle_state", a_state, 0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].op);
      fo[0] = tbl[i].frc;
      fv[0] = tbl[i].fs;
      tick();
      chk("tbl_valid", a_cv, tbl[i].ev);
      chk("tbl_sum", a_exp, tbl[i].es);
      chk("tbl_err", a_ep, tbl[i].ee);
      if (i == 6) begin
        chk("tbl_check_state", a_state, 2);
        chk("tbl_no_err", a_ec, 0);
      end
    end
    fo[0] = 1'b0;
    chk("fault_state", a_state, 3);
    chk("fault_count", a_ec, 1);
    chk("fault_first", a_fe, 9'h011);
    chk("fault_sticky", a_st, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(1, 4, 3, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 9, 2, 1); tick();
    chk("bubble_pre", b_cv, 0);
    drive(0, 0, 0, 0); tick();
    chk("bubble_0", b_cv, 1);
    chk("bubble_sum0", b_exp, 7);
    tick();
    chk("bubble_1", b_cv, 0);
    tick();
    chk("bubble_2", b_cv, 1);
    chk("bubble_sum2", b_exp, 7);
    drive(1, 6, 6, 0); tick();
    drive(1, 7, 1, 1); tick();
    rst = 1'b1;
    drive(0, 0, 0, 0); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_b_valid", b_cv, 0);
      chk("flush_a_valid", a_cv, 0);
    end
    chk("flush_b_count", b_cc, 0);
    chk("flush_b_err", b_ec, 0);
    chk("flush_a_count", a_cc, 0);
    chk("flush_b_state", b_state, 0);
    fm[1] = 6'h01;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      tick();
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    fm[1] = '0;
    chk("sat_err", b_ec, 3);
    chk("sat_chk", b_cc, 5);
    chk("sat_state", b_state, 3);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(3) != 0, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      for (int k = 0; k < 2; k++) fm[k] = ($urandom_range(7) == 0) ? 6'($urandom_range(63, 1)) : 6'h00;
      tick();
    end
    rst = 1'b0;
    fm[0] = '0;
    fm[1] = '0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_addsub_checker.md
Name: sync_addsub_checker

Overview:
- Self-checking monitor on the result side of the registered N-bit add/subtract unit (syncAddnSub) used in the lab06 adder datapath.
- Captures the same operand and opsel stream that drives the adder, computes the expected sum, carry and overflow, and delays them by the adder's latency.
- Compares the adder outputs against the prediction and reports per-sample pass/fail, running counts and the first failing vector. Results go to LEDs or HEX, or to a testbench.

Parameters:
- N, 4, operand/result width in bits.
- LATENCY, 1, cycles from operand sample to valid adder output; legal range 1..4.
- CW, 16, width of the checked-sample counter.
- EW, 8, width of the error counter.

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operand-valid; the current a/b/opsel form one sample.
- a  input  N  operand A, same bits fed to the adder.
- b  input  N  operand B.
- opsel  input  1  0 = A+B, 1 = A-B.
- dut_sum  input  N  adder result.
- dut_carry  input  1  adder carry-out.
- dut_ovf  input  1  adder signed-overflow flag.
- exp_sum  output  N  expected sum for the sample being checked this cycle.
- chk_valid  output  1  a comparison happens this cycle.
- err_pulse  output  1  the comparison this cycle failed.
- err_sticky  output  1  at least one failure since reset.
- chk_count  output  CW  number of comparisons made, saturating.
- err_count  output  EW  number of failures, saturating.
- first_err  output  2N+1  {opsel,a,b} of the first failing sample.
- state  output  2  FSM state, for debug LEDs.

Behaviour:
- Reset (synchronous, active-high) sets:
  - all outputs to 0;
  - the valid pipeline to all 0;
  - state to IDLE.
  - reset wins over every other event in the same cycle.
- Prediction, for the sample captured on an edge where en=1:
  - Add: {c,s} = a + b.
  - Subtract: {c,s} = a + ~b + 1, so c=1 means no borrow.
  - Overflow: ovf = (a[N-1]==bx[N-1]) && (s[N-1]!=a[N-1]), where bx is b for add and ~b for subtract.
  - The tuple {s,c,ovf,opsel,a,b,valid} enters a LATENCY-deep shift register. en=0 inserts an invalid bubble.
- Comparison:
  - When the tuple leaves the pipeline with valid=1, chk_valid=1 and exp_sum=s for that cycle.
  - Mismatch is any difference in {dut_sum,dut_carry,dut_ovf}.
  - chk_valid, err_pulse and exp_sum are registered. They reflect the comparison of dut_* sampled on the same edge on which the tuple reaches the pipeline output.
  - A sample with en=1 on edge k is therefore compared against dut_* sampled on edge k+LATENCY. Flags appear after that edge.
  - When valid=0 at the output: chk_valid=0, err_pulse=0, exp_sum holds its value.
- Counters:
  - chk_count increments on each comparison and saturates at all-ones.
  - err_count increments on each mismatch and saturates at all-ones.
  - err_sticky sets on the first mismatch. first_err loads only on that mismatch and holds until reset.
- FSM, encoded IDLE=0, FILL=1, CHECK=2, FAIL=3:
  - IDLE to FILL on the first en=1.
  - FILL to CHECK when the first valid tuple is compared with no mismatch.
  - FILL to FAIL when that first comparison mismatches.
  - CHECK to FAIL on any mismatch.
  - FAIL is absorbing until reset. Checking and counting continue in FAIL.
  - The pipeline draining to empty does not change state.
- Back-to-back en=1 gives one comparison per cycle with no stalls.
- If reset is asserted mid-stream, all in-flight samples are discarded and never compared.
- Widths: internal prediction is N+1 bits; no other truncation.

Test Plan:
- Reset then idle: hold en=0 for 10 cycles -> chk_valid=0, counts=0, state=IDLE.
- N=4, LATENCY=1, ideal adder model, opsel=0, a=1,b=1 then a=5,b=1 then a=15,b=13:
  - exp_sum = 2, 6, 12 on consecutive cycles, one cycle after each sample;
  - carry 0, 0, 1;
  - err_count=0, state=CHECK.
- Subtract with opsel=1:
  - a=2,b=5 -> exp_sum=13, carry=0, ovf=0;
  - a=8,b=1 -> sum=7, carry=1, ovf=1;
  - model agrees, so no errors.
- Fault injection: force dut_sum to 3 for sample a=1,b=1,add ->
  - err_pulse high for exactly one cycle, err_sticky=1;
  - first_err = {0,4'h1,4'h1}, state=FAIL;
  - later good samples keep state=FAIL and leave err_count at 1.
- Bubbles and reset:
  - en pattern 1,0,1 with LATENCY=3 -> chk_valid pattern 1,0,1 three cycles later.
  - Assert reset while 2 samples are in flight -> no chk_valid afterwards, counts=0.
- Saturation: EW=2, 5 forced mismatches -> err_count stays at 3; chk_count keeps incrementing.
